proc8_c1_sys: RTL and testbench

Four-stage pipelined RV32I-subset processor integrated with a fixed-latency instruction memory that signals data-valid through an output-enable. When the instruction memory is not ready, the processor stalls its fetch stage while later stages continue to drain. This block is the top of the chapter-8 processor experiments and is driven only by clock and reset. Programs are preloaded hierarchically into the instruction memory array.

---
 rtl/proc8_c1_sys_if.sv | 21 ++
 rtl/proc8_c1_sys.sv | 258 +++++++++++++++++++++++++
 tb/tb_proc8_c1_sys.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/proc8_c1_sys_if.sv
// Observation bundle exported by the chapter-8 processor top: fetch state,
// per-stage PCs and the EX-stage ALU view.
interface proc8_c1_sys_if;
    logic [31:0] w_pc;
    logic [31:0] w_ir;
    logic        w_stall;
    logic [31:0] w_p1_pc;
    logic [31:0] w_p2_pc;
    logic [31:0] w_p3_pc;
    logic [31:0] w_in1;
    logic [31:0] w_in2;
    logic [31:0] w_alu;

    modport master (
        output w_pc, w_ir, w_stall, w_p1_pc, w_p2_pc, w_p3_pc, w_in1, w_in2, w_alu
    );

    modport slave (
        input w_pc, w_ir, w_stall, w_p1_pc, w_p2_pc, w_p3_pc, w_in1, w_in2, w_alu
    );
endinterface

// File: rtl/proc8_c1_sys.sv
// Four-stage RV32I-subset pipeline (IF/ID/EX/WB) fed by a fixed-latency
// instruction memory whose output-enable gates the fetch stage.

module proc8_c1_imem #(
    parameter int IMEM_WORDS = 1024,
    parameter int IMEM_LAT   = 2,
    parameter int AW         = 10
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          req,
    input  logic [AW-1:0] addr,
    output logic [31:0]   ir,
    output logic          oe
);
    localparam int CW = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(IMEM_LAT - 1);

    // Contents are loaded from outside through the hierarchy; there is no write port.
    logic [31:0]   mem [0:IMEM_WORDS-1];
    logic [CW-1:0] r_cnt;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_cnt <= '0;
        end else if (req) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign oe = (r_cnt == LAST);
    assign ir = mem[addr];
endmodule

module proc8_c1_cpu #(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic [31:0] w_ir,
    input  logic        w_stall,
    output logic [31:0] r_pc,
    output logic [31:0] P1_pc,
    output logic [31:0] P2_pc,
    output logic [31:0] P3_pc,
    output logic [31:0] w_in1,
    output logic [31:0] w_in2,
    output logic [31:0] w_alu
);
    localparam int DW = $clog2(DMEM_WORDS);
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    typedef enum logic [2:0] {OP_NOP, OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_BNE} op_t;

    logic [31:0] rf   [0:31];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    logic [31:0] P1_ir;
    op_t         P2_op;
    logic [4:0]  P2_rd, P2_rs1, P2_rs2;
    logic [31:0] P2_v1, P2_v2, P2_imm;
    op_t         P3_op;
    logic [4:0]  P3_rd;
    logic [31:0] P3_alu, P3_sdata;

    op_t         d_op;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic [31:0] d_imm, d_v1, d_v2;
    logic [31:0] fwd1, fwd2, ld_data, wb_data;
    logic        wb_we, taken;

    // Unrecognised encodings fall through as NOPs with all register fields zeroed.
    always_comb begin
        d_op  = OP_NOP;
        d_rd  = '0;
        d_rs1 = '0;
        d_rs2 = '0;
        d_imm = '0;
        case (P1_ir[6:0])
            7'b0110011: if (P1_ir[14:12] == 3'b000 && P1_ir[31:25] == 7'b0) begin
                d_op  = OP_ADD;
                d_rd  = P1_ir[11:7];
                d_rs1 = P1_ir[19:15];
                d_rs2 = P1_ir[24:20];
            end
            7'b0010011: if (P1_ir[14:12] == 3'b000) begin
                d_op  = OP_ADDI;
                d_rd  = P1_ir[11:7];
                d_rs1 = P1_ir[19:15];
                d_imm = {{20{P1_ir[31]}}, P1_ir[31:20]};
            end
            7'b0000011: if (P1_ir[14:12] == 3'b010) begin
                d_op  = OP_LW;
                d_rd  = P1_ir[11:7];
                d_rs1 = P1_ir[19:15];
                d_imm = {{20{P1_ir[31]}}, P1_ir[31:20]};
            end
            7'b0100011: if (P1_ir[14:12] == 3'b010) begin
                d_op  = OP_SW;
                d_rs1 = P1_ir[19:15];
                d_rs2 = P1_ir[24:20];
                d_imm = {{20{P1_ir[31]}}, P1_ir[31:25], P1_ir[11:7]};
            end
            7'b1100011: if (P1_ir[14:12] == 3'b001) begin
                d_op  = OP_BNE;
                d_rs1 = P1_ir[19:15];
                d_rs2 = P1_ir[24:20];
                d_imm = {{19{P1_ir[31]}}, P1_ir[31], P1_ir[7], P1_ir[30:25], P1_ir[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    // WB side: combinational load, so a dependent instruction one behind needs no stall.
    assign ld_data = dmem[P3_alu[DW+1:2]];
    assign wb_data = (P3_op == OP_LW) ? ld_data : P3_alu;
    assign wb_we   = (P3_op == OP_ADD || P3_op == OP_ADDI || P3_op == OP_LW) && (P3_rd != 5'd0);

    always_comb begin
        d_v1 = '0;
        d_v2 = '0;
        if (d_rs1 != 5'd0) d_v1 = (wb_we && P3_rd == d_rs1) ? wb_data : rf[d_rs1];
        if (d_rs2 != 5'd0) d_v2 = (wb_we && P3_rd == d_rs2) ? wb_data : rf[d_rs2];
    end

    always_comb begin
        fwd1  = (wb_we && P3_rd == P2_rs1) ? wb_data : P2_v1;
        fwd2  = (wb_we && P3_rd == P2_rs2) ? wb_data : P2_v2;
        w_in1 = fwd1;
        w_in2 = (P2_op == OP_ADDI || P2_op == OP_LW || P2_op == OP_SW) ? P2_imm : fwd2;
        w_alu = (P2_op == OP_BNE) ? {31'b0, w_in1 != w_in2} : w_in1 + w_in2;
        taken = (P2_op == OP_BNE) && w_alu[0];
    end

    // A taken branch wins over the fetch stall and squashes the ID and EX slots.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_pc     <= '0;
            P1_pc    <= '0;
            P1_ir    <= NOP_IR;
            P2_pc    <= '0;
            P2_op    <= OP_NOP;
            P2_rd    <= '0;
            P2_rs1   <= '0;
            P2_rs2   <= '0;
            P2_v1    <= '0;
            P2_v2    <= '0;
            P2_imm   <= '0;
            P3_pc    <= '0;
            P3_op    <= OP_NOP;
            P3_rd    <= '0;
            P3_alu   <= '0;
            P3_sdata <= '0;
        end else begin
            if (taken) begin
                r_pc <= P2_pc + P2_imm;
            end else if (!w_stall) begin
                r_pc <= r_pc + 32'd4;
            end

            if (taken || w_stall) begin
                P1_pc <= '0;
                P1_ir <= NOP_IR;
            end else begin
                P1_pc <= r_pc;
                P1_ir <= w_ir;
            end

            if (taken) begin
                P2_pc  <= '0;
                P2_op  <= OP_NOP;
                P2_rd  <= '0;
                P2_rs1 <= '0;
                P2_rs2 <= '0;
                P2_v1  <= '0;
                P2_v2  <= '0;
                P2_imm <= '0;
            end else begin
                P2_pc  <= P1_pc;
                P2_op  <= d_op;
                P2_rd  <= d_rd;
                P2_rs1 <= d_rs1;
                P2_rs2 <= d_rs2;
                P2_v1  <= d_v1;
                P2_v2  <= d_v2;
                P2_imm <= d_imm;
            end

            P3_pc    <= P2_pc;
            P3_op    <= P2_op;
            P3_rd    <= P2_rd;
            P3_alu   <= w_alu;
            P3_sdata <= fwd2;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[P3_rd] <= wb_data;
        end
    end

    always_ff @(posedge w_clk) begin
        if (P3_op == OP_SW) dmem[P3_alu[DW+1:2]] <= P3_sdata;
    end
endmodule

module proc8_c1_sys #(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024,
    parameter int IMEM_LAT   = 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    proc8_c1_sys_if.master        dbg
);
    localparam int IAW = $clog2(IMEM_WORDS);

    logic [31:0] w_pc, w_ir, w_p1_pc, w_p2_pc, w_p3_pc, w_in1, w_in2, w_alu;
    logic        oe, w_stall;

    assign w_stall = !oe;

    proc8_c1_cpu #(.DMEM_WORDS(DMEM_WORDS)) u1 (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .w_ir    (w_ir),
        .w_stall (w_stall),
        .r_pc    (w_pc),
        .P1_pc   (w_p1_pc),
        .P2_pc   (w_p2_pc),
        .P3_pc   (w_p3_pc),
        .w_in1   (w_in1),
        .w_in2   (w_in2),
        .w_alu   (w_alu)
    );

    proc8_c1_imem #(.IMEM_WORDS(IMEM_WORDS), .IMEM_LAT(IMEM_LAT), .AW(IAW)) u2 (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .req   (1'b1),
        .addr  (w_pc[IAW+1:2]),
        .ir    (w_ir),
        .oe    (oe)
    );

    assign dbg.w_pc    = w_pc;
    assign dbg.w_ir    = w_ir;
    assign dbg.w_stall = w_stall;
    assign dbg.w_p1_pc = w_p1_pc;
    assign dbg.w_p2_pc = w_p2_pc;
    assign dbg.w_p3_pc = w_p3_pc;
    assign dbg.w_in1   = w_in1;
    assign dbg.w_in2   = w_in2;
    assign dbg.w_alu   = w_alu;
endmodule

// File: tb/tb_proc8_c1_sys.sv
// Directed bench: four instances at different imem latencies running short
// hand-assembled programs, checked cycle by cycle against hand-derived values.
module tb_proc8_c1_sys;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;
    localparam logic [31:0] ADDI_X1_1 = 32'h0010_0093;
    localparam logic [31:0] BNE_M4    = 32'hFE00_9EE3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    proc8_c1_sys_if if_a ();
    proc8_c1_sys_if if_b ();
    proc8_c1_sys_if if_c ();
    proc8_c1_sys_if if_d ();

    proc8_c1_sys #(.IMEM_LAT(2)) dut_a (.w_clk(clk), .w_rst(rst), .dbg(if_a));
    proc8_c1_sys #(.IMEM_LAT(1)) dut_b (.w_clk(clk), .w_rst(rst), .dbg(if_b));
    proc8_c1_sys #(.IMEM_LAT(1)) dut_c (.w_clk(clk), .w_rst(rst), .dbg(if_c));
    proc8_c1_sys #(.IMEM_LAT(3)) dut_d (.w_clk(clk), .w_rst(rst), .dbg(if_d));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One reset edge; on return the bench sits mid-way through cycle 0.
    task automatic applyStimulus();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic advanceTo(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            dut_a.u2.mem[i] = NOP;
            dut_b.u2.mem[i] = NOP;
            dut_c.u2.mem[i] = NOP;
            dut_d.u2.mem[i] = NOP;
        end
        dut_a.u2.mem[0] = ADDI_X1_5;
        dut_b.u2.mem[0] = ADDI_X1_5;
        dut_b.u2.mem[1] = 32'h0030_8113;
        dut_b.u2.mem[2] = 32'h0020_81B3;
        dut_b.u2.mem[3] = 32'h0030_2423;
        dut_b.u2.mem[4] = 32'h0080_2203;
        dut_b.u2.mem[5] = 32'h0042_02B3;
        dut_c.u2.mem[0] = ADDI_X1_1;
        dut_c.u2.mem[1] = BNE_M4;
        dut_d.u2.mem[0] = ADDI_X1_1;
        dut_d.u2.mem[1] = BNE_M4;

        applyStimulus();
        $display("[TB] reset released, running directed programs");

        checkOutput("a_pc_c0", if_a.w_pc, 32'd0);
        checkOutput("a_stall_c0", {31'b0, if_a.w_stall}, 32'd1);
        checkOutput("b_pc_c0", if_b.w_pc, 32'd0);
        checkOutput("b_p1_c0", if_b.w_p1_pc, 32'd0);
        checkOutput("b_p2_c0", if_b.w_p2_pc, 32'd0);
        checkOutput("b_p3_c0", if_b.w_p3_pc, 32'd0);
        checkOutput("b_stall_c0", {31'b0, if_b.w_stall}, 32'd0);
        checkOutput("b_x5_c0", dut_b.u1.rf[5], 32'd0);
        checkOutput("d_stall_c0", {31'b0, if_d.w_stall}, 32'd1);

        advanceTo(1);
        checkOutput("a_stall_c1", {31'b0, if_a.w_stall}, 32'd0);
        checkOutput("a_pc_c1", if_a.w_pc, 32'd0);
        checkOutput("d_stall_c1", {31'b0, if_d.w_stall}, 32'd1);

        advanceTo(2);
        checkOutput("a_stall_c2", {31'b0, if_a.w_stall}, 32'd1);
        checkOutput("a_pc_c2", if_a.w_pc, 32'd4);
        checkOutput("b_alu_c2", if_b.w_alu, 32'd5);
        checkOutput("d_stall_c2", {31'b0, if_d.w_stall}, 32'd0);
        checkOutput("d_ir_c2", if_d.w_ir, ADDI_X1_1);

        advanceTo(3);
        checkOutput("a_stall_c3", {31'b0, if_a.w_stall}, 32'd0);
        checkOutput("a_pc_c3", if_a.w_pc, 32'd4);
        checkOutput("a_alu_c3", if_a.w_alu, 32'd5);
        checkOutput("b_alu_c3", if_b.w_alu, 32'd8);
        checkOutput("b_in1_c3", if_b.w_in1, 32'd5);
        checkOutput("c_alu_c3", if_c.w_alu, 32'd1);
        checkOutput("c_p2_c3", if_c.w_p2_pc, 32'd4);
        checkOutput("d_pc_c3", if_d.w_pc, 32'd4);

        advanceTo(4);
        checkOutput("a_pc_c4", if_a.w_pc, 32'd8);
        checkOutput("b_alu_c4", if_b.w_alu, 32'd13);
        checkOutput("b_in1_c4", if_b.w_in1, 32'd5);
        checkOutput("b_in2_c4", if_b.w_in2, 32'd8);
        checkOutput("c_pc_c4", if_c.w_pc, 32'd0);
        checkOutput("c_p1_c4", if_c.w_p1_pc, 32'd0);
        checkOutput("c_p2_c4", if_c.w_p2_pc, 32'd0);

        advanceTo(5);
        checkOutput("b_alu_c5", if_b.w_alu, 32'd8);
        checkOutput("c_pc_c5", if_c.w_pc, 32'd4);
        checkOutput("c_p3_c5", if_c.w_p3_pc, 32'd0);
        checkOutput("d_stall_c5", {31'b0, if_d.w_stall}, 32'd0);
        checkOutput("d_pc_c5", if_d.w_pc, 32'd4);

        advanceTo(6);
        checkOutput("b_alu_c6", if_b.w_alu, 32'd8);
        checkOutput("d_pc_c6", if_d.w_pc, 32'd8);
        checkOutput("d_stall_c6", {31'b0, if_d.w_stall}, 32'd1);

        advanceTo(7);
        checkOutput("b_in1_c7", if_b.w_in1, 32'd13);
        checkOutput("b_in2_c7", if_b.w_in2, 32'd13);
        checkOutput("b_alu_c7", if_b.w_alu, 32'd26);
        checkOutput("b_stall_c7", {31'b0, if_b.w_stall}, 32'd0);
        checkOutput("c_p2_c7", if_c.w_p2_pc, 32'd4);
        checkOutput("c_alu_c7", if_c.w_alu, 32'd1);
        checkOutput("d_stall_c7", {31'b0, if_d.w_stall}, 32'd1);
        checkOutput("d_pc_c7", if_d.w_pc, 32'd8);
        checkOutput("d_p2_c7", if_d.w_p2_pc, 32'd4);
        checkOutput("d_alu_c7", if_d.w_alu, 32'd1);

        advanceTo(8);
        checkOutput("b_x4_c8", dut_b.u1.rf[4], 32'd13);
        checkOutput("c_pc_c8", if_c.w_pc, 32'd0);
        checkOutput("d_pc_c8", if_d.w_pc, 32'd0);
        checkOutput("d_stall_c8", {31'b0, if_d.w_stall}, 32'd0);
        checkOutput("d_ir_c8", if_d.w_ir, ADDI_X1_1);

        advanceTo(9);
        checkOutput("b_x5_c9", dut_b.u1.rf[5], 32'd26);
        checkOutput("d_pc_c9", if_d.w_pc, 32'd4);

        advanceTo(10);
        checkOutput("d_p2_c10", if_d.w_p2_pc, 32'd0);
        checkOutput("d_alu_c10", if_d.w_alu, 32'd1);
        checkOutput("d_in2_c10", if_d.w_in2, 32'd1);

        applyStimulus();
        checkOutput("a_stall_r0", {31'b0, if_a.w_stall}, 32'd1);
        checkOutput("b_pc_r0", if_b.w_pc, 32'd0);
        checkOutput("b_p1_r0", if_b.w_p1_pc, 32'd0);
        checkOutput("b_p2_r0", if_b.w_p2_pc, 32'd0);
        checkOutput("b_p3_r0", if_b.w_p3_pc, 32'd0);
        checkOutput("b_x5_r0", dut_b.u1.rf[5], 32'd0);
        checkOutput("c_pc_r0", if_c.w_pc, 32'd0);
        checkOutput("d_pc_r0", if_d.w_pc, 32'd0);

        advanceTo(2);
        checkOutput("b_alu_r2", if_b.w_alu, 32'd5);
        advanceTo(3);
        checkOutput("b_alu_r3", if_b.w_alu, 32'd8);
        advanceTo(4);
        checkOutput("b_alu_r4", if_b.w_alu, 32'd13);
        advanceTo(7);
        checkOutput("b_alu_r7", if_b.w_alu, 32'd26);
        advanceTo(9);
        checkOutput("b_x5_r9", dut_b.u1.rf[5], 32'd26);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
